// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: default sizes and the
// functional-unit index assignment used by every producer on the bus.
package cdb_arbiter_pkg;

    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_TAG_W   = 5;
    localparam int CDB_DATA_W  = 32;

    localparam int UNIT_ADD  = 0;
    localparam int UNIT_MUL  = 1;
    localparam int UNIT_DIV  = 2;
    localparam int UNIT_LOAD = 3;

    // Index width that stays legal for a single-source configuration.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request scanning upward from
// rr_ptr with wrap-around, returned both one-hot and encoded.
module rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int N  = DEF_NUM_SRC,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  require,
    input  logic [IW-1:0] rr_ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          valid
);

    logic [IW-1:0] cand [N];

    // cand[k] is the unit visited k steps after rr_ptr, modulo N.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum       = {1'b0, rr_ptr} + (IW+1)'(gi);
        assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    end

    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (enable && !valid && require[cand[k]]) begin
                grant[cand[k]] = 1'b1;
                index          = cand[k];
                valid          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one round-robin grant per cycle, with the granted
// unit's result and tag broadcast from registers one cycle later.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int IW      = idx_width(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          nRST,
    input  logic [NUM_SRC-1:0]            require,
    input  logic [CDB_DATA_W*NUM_SRC-1:0] reqData,
    input  logic [TAG_W*NUM_SRC-1:0]      reqTag,
    input  logic                          cdbStall,
    output logic [NUM_SRC-1:0]            requireAC,
    output logic                          cdbValid,
    output logic [CDB_DATA_W-1:0]         cdbData,
    output logic [TAG_W-1:0]              cdbTag,
    output logic [IW-1:0]                 cdbSrc
);

    logic [IW-1:0]         rr_ptr_reg;
    logic                  valid_reg;
    logic [CDB_DATA_W-1:0] data_reg;
    logic [TAG_W-1:0]      tag_reg;
    logic [IW-1:0]         src_reg;

    logic [NUM_SRC-1:0]    grant;
    logic [IW-1:0]         pick;
    logic                  pick_valid;
    logic [CDB_DATA_W-1:0] sel_data;
    logic [TAG_W-1:0]      sel_tag;
    logic [IW-1:0]         rr_ptr_next;

    // Gating with nRST keeps the grant low during reset without a clock.
    rr_picker #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_picker (
        .require (require),
        .rr_ptr  (rr_ptr_reg),
        .enable  (nRST && !cdbStall),
        .grant   (grant),
        .index   (pick),
        .valid   (pick_valid)
    );

    assign requireAC = grant;

    // Grant is one-hot, so an OR of masked lanes selects the winner.
    always_comb begin
        sel_data = '0;
        sel_tag  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant[k]) begin
                sel_data = sel_data | reqData[CDB_DATA_W*k +: CDB_DATA_W];
                sel_tag  = sel_tag  | reqTag[TAG_W*k +: TAG_W];
            end
        end
    end

    assign rr_ptr_next = (pick == IW'(NUM_SRC - 1)) ? '0 : pick + IW'(1);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_reg <= '0;
            valid_reg  <= 1'b0;
            data_reg   <= '0;
            tag_reg    <= '0;
            src_reg    <= '0;
        end else begin
            valid_reg <= pick_valid;
            if (pick_valid) begin
                rr_ptr_reg <= rr_ptr_next;
                data_reg   <= sel_data;
                tag_reg    <= sel_tag;
                src_reg    <= pick;
            end
        end
    end

    assign cdbValid = valid_reg;
    assign cdbData  = data_reg;
    assign cdbTag   = tag_reg;
    assign cdbSrc   = src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: each cycle checks the combinational grant,
// then the registered broadcast one edge later.
module tb_cdb_arbiter;

    logic         clk;
    logic         nRST;
    logic [3:0]   require;
    logic [127:0] reqData;
    logic [19:0]  reqTag;
    logic         cdbStall;
    logic [3:0]   requireAC;
    logic         cdbValid;
    logic [31:0]  cdbData;
    logic [4:0]   cdbTag;
    logic [1:0]   cdbSrc;

    int total = 0;
    int bad   = 0;

    logic [31:0] data_tab [4];
    logic [4:0]  tag_tab  [4];
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [4:0]  exp_tag;
    logic [1:0]  exp_src;

    cdb_arbiter dut (
        .clk       (clk),
        .nRST      (nRST),
        .require   (require),
        .reqData   (reqData),
        .reqTag    (reqTag),
        .cdbStall  (cdbStall),
        .requireAC (requireAC),
        .cdbValid  (cdbValid),
        .cdbData   (cdbData),
        .cdbTag    (cdbTag),
        .cdbSrc    (cdbSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_tabs();
        for (int i = 0; i < 4; i++) begin
            reqData[32*i +: 32] = data_tab[i];
            reqTag[5*i +: 5]    = tag_tab[i];
        end
    endtask

    task automatic check_bus(input string name);
        chk({name, ".valid"}, 32'(cdbValid), 32'(exp_valid));
        chk({name, ".data"},  cdbData, exp_data);
        chk({name, ".tag"},   32'(cdbTag), 32'(exp_tag));
        chk({name, ".src"},   32'(cdbSrc), 32'(exp_src));
    endtask

    // One cycle: drive, check grant, clock, check broadcast. g < 0 means no grant.
    task automatic step(input string name, input logic [3:0] req, input logic stall, input int g);
        logic [3:0] exp_gnt;
        require  = req;
        cdbStall = stall;
        load_tabs();
        exp_gnt = (g < 0) ? 4'b0000 : 4'(1 << g);
        #1;
        chk({name, ".ac"}, 32'(requireAC), 32'(exp_gnt));
        @(posedge clk);
        #1;
        if (g < 0) begin
            exp_valid = 1'b0;
        end else begin
            exp_valid = 1'b1;
            exp_data  = data_tab[g];
            exp_tag   = tag_tab[g];
            exp_src   = 2'(g);
        end
        $display("cycle %s req=%b stall=%b ac=%b valid=%b src=%0d tag=%0d data=%h",
                 name, req, stall, requireAC, cdbValid, cdbSrc, cdbTag, cdbData);
        check_bus(name);
    endtask

    task automatic pulse_reset(input string name);
        nRST = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_tag   = '0;
        exp_src   = '0;
        #1;
        chk({name, ".ac"}, 32'(requireAC), 32'h0);
        check_bus(name);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        data_tab[0] = 32'h1111_0000; tag_tab[0] = 5'd0;
        data_tab[1] = 32'h0000_0C35; tag_tab[1] = 5'd7;
        data_tab[2] = 32'h2222_2222; tag_tab[2] = 5'd19;
        data_tab[3] = 32'h3333_3333; tag_tab[3] = 5'd31;
        nRST = 1'b0;
        require = 4'b1111;
        cdbStall = 1'b0;
        load_tabs();
        exp_valid = 1'b0; exp_data = '0; exp_tag = '0; exp_src = '0;

        // Reset held across an edge with requests pending.
        #2;
        chk("rst.ac", 32'(requireAC), 32'h0);
        check_bus("rst");
        @(posedge clk);
        #1;
        check_bus("rst_edge");
        nRST = 1'b1;

        for (int i = 0; i < 3; i++) step("idle", 4'b0000, 1'b0, -1);

        step("single1", 4'b0010, 1'b0, 1);

        // Full request from reset: strict rotation 0,1,2,3,0,1,2,3.
        @(posedge clk); #1;
        pulse_reset("rst2");
        for (int i = 0; i < 8; i++) step("rr_all", 4'b1111, 1'b0, i % 4);

        step("set_ptr2", 4'b0010, 1'b0, 1);
        step("sparse_a", 4'b1010, 1'b0, 3);
        data_tab[1] = 32'hBEEF_0001;
        step("sparse_b", 4'b1010, 1'b0, 1);
        step("sparse_c", 4'b1010, 1'b0, 3);

        step("stall_a", 4'b0100, 1'b1, -1);
        step("stall_b", 4'b0100, 1'b1, -1);
        step("stall_go", 4'b0100, 1'b0, 2);

        // Back-to-back requester with fresh data, tag 0.
        step("b2b_a", 4'b0001, 1'b0, 0);
        data_tab[0] = 32'hCAFE_0000;
        step("b2b_b", 4'b0001, 1'b0, 0);
        step("b2b_c", 4'b0011, 1'b0, 1);

        // Pointer now 2; reset must bring it back to 0.
        pulse_reset("rst_ptr");
        step("after_rst", 4'b0101, 1'b0, 0);

        // Grant to unit 2 is cut by reset before its edge.
        require  = 4'b0100;
        cdbStall = 1'b0;
        #1;
        chk("inflight.ac", 32'(requireAC), 32'h4);
        require = 4'b0000;
        pulse_reset("inflight");
        @(posedge clk);
        #1;
        check_bus("inflight_edge");
        step("post_rst", 4'b0101, 1'b0, 0);

        // Request dropped before the edge leaves nothing behind.
        require = 4'b1000;
        #1;
        step("dropped", 4'b0000, 1'b0, -1);
        step("next", 4'b0110, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of functional units competing for the common data bus (CDB).
REQ-002 Parameter TAG_W, default 5: reservation-station tag width.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port nRST  input  1: asynchronous, active-low reset.
REQ-005 Port require  input  NUM_SRC: bit i high = unit i holds a finished result and requests the CDB.
REQ-006 Port reqData  input  32*NUM_SRC: result of unit i at bits [32i+31:32i].
REQ-007 Port reqTag  input  TAG_W*NUM_SRC: destination tag of unit i at bits [TAG_W*i+TAG_W-1:TAG_W*i].
REQ-008 Port cdbStall  input  1: high = no grant this cycle (consumer back-pressure).
REQ-009 Port requireAC  output  NUM_SRC: grant; bit i high = unit i's result is taken at the next rising edge.
REQ-010 Port cdbValid  output  1: registered broadcast valid.
REQ-011 Port cdbData  output  32: registered broadcast result.
REQ-012 Port cdbTag  output  TAG_W: registered broadcast tag.
REQ-013 Port cdbSrc  output  clog2(NUM_SRC): index of the unit that produced the current broadcast.

Function
REQ-014 requireAC SHALL be combinational from require, rrPtr, cdbStall and nRST; zero or one-hot, never multi-hot.
REQ-015 requireAC[i] SHALL never be high while require[i] is low.
REQ-016 With cdbStall low and require nonzero, grant SHALL go to the first set require bit scanning upward from rrPtr, wrapping from NUM_SRC-1 to 0.
REQ-017 cdbStall high or require zero SHALL force requireAC to all zeros.
REQ-018 At a rising edge with grant g: cdbValid<=1, cdbData<=reqData[g], cdbTag<=reqTag[g], cdbSrc<=g; latency from grant to broadcast SHALL be exactly one cycle.
REQ-019 At a rising edge with no grant: cdbValid<=0; cdbData, cdbTag, cdbSrc SHALL hold.
REQ-020 rrPtr SHALL update to (g+1) mod NUM_SRC on a grant and hold otherwise.
REQ-021 Fairness: with require held all-ones and cdbStall low, every unit SHALL be granted exactly once in any NUM_SRC consecutive cycles.
REQ-022 A unit requesting back-to-back (granted, then re-requesting with new data in the next cycle) SHALL be treated as a fresh request under normal priority.
REQ-023 The arbiter SHALL NOT inspect tag or data values; tag 0 is broadcast like any other tag.
REQ-024 Grants depend only on current-cycle inputs; a request dropped before the edge SHALL NOT be remembered.

Reset
REQ-025 nRST low SHALL immediately (without clock) force rrPtr=0, cdbValid=0, cdbData=0, cdbTag=0, cdbSrc=0, and requireAC all zeros.
REQ-026 Reset asserted mid-broadcast SHALL drop the in-flight result; the first grant after release SHALL go to the lowest-index requester.

Structure
REQ-027 NUM_SRC, TAG_W and the unit index constants (adder 0, multiplier 1, divider 2, load 3) SHALL live in the shared header include.
REQ-028 The round-robin priority pick SHALL be a combinational sub-module rr_picker (inputs require, rrPtr, enable; output one-hot grant plus encoded index); cdb_arbiter owns all registers.

Verification
REQ-029 Reset release, require=4'b0000 for 3 cycles -> requireAC=0, cdbValid=0, cdbData=0 every cycle.
REQ-030 require=4'b0010, reqData[1]=32'h0000_0C35, reqTag[1]=5'd7 -> requireAC=4'b0010 same cycle; next cycle cdbValid=1, cdbData=32'h0000_0C35, cdbTag=7, cdbSrc=1.
REQ-031 require=4'b1111 held 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; cdbSrc lags by one cycle.
REQ-032 require=4'b1010 with rrPtr=2 -> grant unit 3, then unit 1, then unit 3.
REQ-033 require=4'b0100 with cdbStall=1 for 2 cycles, then 0 -> no grant and cdbValid=0 while stalled; grant to unit 2 in the cycle stall drops.
REQ-034 nRST pulsed low between a grant to unit 2 and the following edge -> cdbValid stays 0, rrPtr=0; next require=4'b0101 grants unit 0.
